baccarat_fsm: RTL
=================

BACCARAT_FSM -- requirements
Module: baccarat_fsm

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 slow_clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 resetb  input  1  asynchronous, active-low reset.
REQ-004 pscore  input  4  player hand score from datapath, 0-9, combinational from the card registers.
REQ-005 dscore  input  4  dealer hand score from datapath, 0-9.
REQ-006 pcard3  input  4  player third-card rank, 0 = none, 1-13 = A..K.
REQ-007 load_pcard1, load_pcard2, load_pcard3  output  1 each  player card-register load enables.
REQ-008 load_dcard1, load_dcard2, load_dcard3  output  1 each  dealer card-register load enables.
REQ-009 player_win_light, dealer_win_light  output  1 each  game result indicators.

Function
REQ-010 The block SHALL be a Moore FSM; all outputs are decoded from the state register or registered, never from inputs.
REQ-011 States SHALL be: DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, EVAL, P_DRAW3, D_EVAL, D_DRAW3, RESULT, DONE.
REQ-012 DEAL_P1->DEAL_D1->DEAL_P2->DEAL_D2->EVAL SHALL advance one state per slow_clock edge, unconditionally.
REQ-013 Each DEAL_x / P_DRAW3 / D_DRAW3 state SHALL assert exactly its one load enable; the card is captured on the edge leaving that state; at most one load enable is high in any cycle.
REQ-014 EVAL: if pscore>=8 or dscore>=8 (natural), go to RESULT.
REQ-015 EVAL, no natural, pscore<=5: go to P_DRAW3.
REQ-016 EVAL, no natural, pscore 6-7: go to D_DRAW3 if dscore<=5, else RESULT.
REQ-017 P_DRAW3 SHALL always go to D_EVAL, where pcard3 and updated pscore are valid.
REQ-018 D_EVAL: with v = pcard3 value (rank 1-9 -> rank, 10-13 -> 0), go to D_DRAW3 when dscore 0-2; dscore 3 and v!=8; dscore 4 and v in 2-7; dscore 5 and v in 4-7; dscore 6 and v in 6-7. Otherwise (including dscore 7) go to RESULT.
REQ-019 D_DRAW3 SHALL always go to RESULT.
REQ-020 RESULT SHALL go to DONE; on that edge player_win_light <= (pscore>dscore)|(pscore==dscore), dealer_win_light <= (dscore>pscore)|(pscore==dscore); a tie lights both.
REQ-021 DONE SHALL be terminal: hold lights, all loads 0, until resetb asserts.
REQ-022 Win lights SHALL be 0 in every state other than DONE.
REQ-023 Latency: natural game loads in cycles 0-3, EVAL cycle 4, RESULT cycle 5, lights high from cycle 6; longest game (both draw) lights high from cycle 9.
REQ-024 pscore/dscore values 10-15 SHALL be treated as >=8 (natural); pcard3 ranks 14-15 SHALL be treated as value 0.

Reset
REQ-025 resetb low SHALL, asynchronously and regardless of state, force state DEAL_P1 and both lights to 0.
REQ-026 During and immediately after reset, load_pcard1 SHALL be 1 (decoded from DEAL_P1) and all other loads 0.
REQ-027 Reset mid-game SHALL abandon the game with no further draw; the first edge after release loads pcard1.

Structure
REQ-028 A shared package SHALL hold the state enum typedef, the NATURAL_MIN (8) and DRAW_MAX (5) constants, and a card_value function (rank->0-9).
REQ-029 Banker third-card rule SHALL be one sub-module, banker_rule (inputs dscore, pcard3; output draw), combinational.
REQ-030 Top-level datapath integration SHALL connect this block's loads and inputs to the datapath ports of the same names.

Verification
REQ-031 Natural: P=4,5 (pscore 9), D=3,2 -> no load_pcard3/load_dcard3 ever; cycle 6 player_win_light=1, dealer_win_light=0.
REQ-032 Player stands, dealer draws: P=3,3 (6), D=2,2 (4) -> load_dcard3 in cycle 5; D3=5 (dscore 9) -> dealer_win_light=1 only.
REQ-033 Player draws, dealer stands: P=1,2 (3), D=1,2 (3), pcard3=8 -> D_EVAL goes to RESULT; pscore 1 vs 3 -> dealer_win_light=1.
REQ-034 Banker rule 6: dscore 6, pscore 5, pcard3=7 -> load_dcard3; repeat with pcard3=12 (Q, value 0) -> no load_dcard3.
REQ-035 Tie: P=3,4, D=5,2 (7 vs 7) -> EVAL->RESULT; both lights 1 in DONE, held for 10+ cycles.
REQ-036 Reset mid-game: drop resetb in P_DRAW3, asynchronously -> all loads except load_pcard1 and both lights 0 immediately; after release, first edge loads pcard1.

Source files
------------

// File: rtl/baccarat_fsm_pkg.sv
// Shared types, thresholds and card-rank helper for the baccarat game controller.
package baccarat_fsm_pkg;

  typedef enum logic [3:0] {
    DEAL_P1 = 4'd0,
    DEAL_D1 = 4'd1,
    DEAL_P2 = 4'd2,
    DEAL_D2 = 4'd3,
    EVAL    = 4'd4,
    P_DRAW3 = 4'd5,
    D_EVAL  = 4'd6,
    D_DRAW3 = 4'd7,
    RESULT  = 4'd8,
    DONE    = 4'd9
  } state_t;

  localparam logic [3:0] NATURAL_MIN = 4'd8;
  localparam logic [3:0] DRAW_MAX    = 4'd5;

  // Ranks A..9 count face value; 10, J, Q, K, "none" and unused codes count zero.
  function automatic logic [3:0] card_value(input logic [3:0] rank);
    logic [3:0] value_s;
    if ((rank >= 4'd1) && (rank <= 4'd9)) begin
      value_s = rank;
    end else begin
      value_s = 4'd0;
    end
    return value_s;
  endfunction

endpackage

// File: rtl/baccarat_fsm_if.sv
// Controller <-> card datapath connection: scores in, load enables and result lights out.
interface baccarat_fsm_if;
  logic [3:0] pscore;
  logic [3:0] dscore;
  logic [3:0] pcard3;
  logic       load_pcard1;
  logic       load_pcard2;
  logic       load_pcard3;
  logic       load_dcard1;
  logic       load_dcard2;
  logic       load_dcard3;
  logic       player_win_light;
  logic       dealer_win_light;

  modport master (
    input  pscore, dscore, pcard3,
    output load_pcard1, load_pcard2, load_pcard3,
    output load_dcard1, load_dcard2, load_dcard3,
    output player_win_light, dealer_win_light
  );

  modport slave (
    output pscore, dscore, pcard3,
    input  load_pcard1, load_pcard2, load_pcard3,
    input  load_dcard1, load_dcard2, load_dcard3,
    input  player_win_light, dealer_win_light
  );
endinterface

// File: rtl/baccarat_fsm_banker_rule.sv
// Banker third-card decision from the dealer's two-card score and the player's third card.
module banker_rule
  import baccarat_fsm_pkg::*;
(
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       draw
);

  logic [3:0] v_s;

  // Tableau lookup; scores 7 and above (including out-of-range codes) always stand.
  always_comb begin
    draw = 1'b0;
    v_s  = card_value(pcard3);
    case (dscore)
      4'd0, 4'd1, 4'd2: draw = 1'b1;
      4'd3:             draw = (v_s != 4'd8);
      4'd4:             draw = (v_s >= 4'd2) && (v_s <= 4'd7);
      4'd5:             draw = (v_s >= 4'd4) && (v_s <= 4'd7);
      4'd6:             draw = (v_s >= 4'd6) && (v_s <= 4'd7);
      default:          draw = 1'b0;
    endcase
  end

endmodule

// File: rtl/baccarat_fsm.sv
// Baccarat game sequencer: deals four cards, applies third-card rules, latches the result.
module baccarat_fsm
  import baccarat_fsm_pkg::*;
(
  input  logic           slow_clock,
  input  logic           resetb,
  baccarat_fsm_if.master bus
);

  // Load vector bit order: {pcard1, pcard2, pcard3, dcard1, dcard2, dcard3}
  localparam logic [5:0] LOAD_NONE = 6'b000000;
  localparam logic [5:0] LOAD_P1   = 6'b100000;

  state_t     state_r;
  state_t     next_state_s;
  logic [5:0] load_r;
  logic       player_win_r;
  logic       dealer_win_r;
  logic       bank_draw_s;

  function automatic logic [5:0] load_decode(input state_t s);
    logic [5:0] l_s;
    case (s)
      DEAL_P1: l_s = 6'b100000;
      DEAL_P2: l_s = 6'b010000;
      P_DRAW3: l_s = 6'b001000;
      DEAL_D1: l_s = 6'b000100;
      DEAL_D2: l_s = 6'b000010;
      D_DRAW3: l_s = 6'b000001;
      default: l_s = LOAD_NONE;
    endcase
    return l_s;
  endfunction

  banker_rule u_banker_rule (
    .dscore (bus.dscore),
    .pcard3 (bus.pcard3),
    .draw   (bank_draw_s)
  );

  // Next-state selection; scores read in EVAL/D_EVAL are the ones the datapath just settled.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      DEAL_P1: next_state_s = DEAL_D1;
      DEAL_D1: next_state_s = DEAL_P2;
      DEAL_P2: next_state_s = DEAL_D2;
      DEAL_D2: next_state_s = EVAL;
      EVAL: begin
        if ((bus.pscore >= NATURAL_MIN) || (bus.dscore >= NATURAL_MIN)) begin
          next_state_s = RESULT;
        end else if (bus.pscore <= DRAW_MAX) begin
          next_state_s = P_DRAW3;
        end else if (bus.dscore <= DRAW_MAX) begin
          next_state_s = D_DRAW3;
        end else begin
          next_state_s = RESULT;
        end
      end
      P_DRAW3: next_state_s = D_EVAL;
      D_EVAL: begin
        if (bank_draw_s) begin
          next_state_s = D_DRAW3;
        end else begin
          next_state_s = RESULT;
        end
      end
      D_DRAW3: next_state_s = RESULT;
      RESULT:  next_state_s = DONE;
      DONE:    next_state_s = DONE;
      default: next_state_s = DEAL_P1;
    endcase
  end

  // State plus registered outputs; loads are pre-decoded from the next state so they track state_r.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state_r      <= DEAL_P1;
      load_r       <= LOAD_P1;
      player_win_r <= 1'b0;
      dealer_win_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      load_r  <= load_decode(next_state_s);
      if (state_r == RESULT) begin
        player_win_r <= (bus.pscore >= bus.dscore);
        dealer_win_r <= (bus.dscore >= bus.pscore);
      end else if (state_r == DONE) begin
        player_win_r <= player_win_r;
        dealer_win_r <= dealer_win_r;
      end else begin
        player_win_r <= 1'b0;
        dealer_win_r <= 1'b0;
      end
    end
  end

  assign bus.load_pcard1      = load_r[5];
  assign bus.load_pcard2      = load_r[4];
  assign bus.load_pcard3      = load_r[3];
  assign bus.load_dcard1      = load_r[2];
  assign bus.load_dcard2      = load_r[1];
  assign bus.load_dcard3      = load_r[0];
  assign bus.player_win_light = player_win_r;
  assign bus.dealer_win_light = dealer_win_r;

endmodule
